// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the word-indexed data memory (MEM stage)
// Ports:
//   clk, SYS_reset           clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; ready only while idle
//   req_write/size/signed    store flag, 00 byte / 01 half / 10 word, sign-extend loads
//   req_addr/req_wdata       byte address, right-aligned store data
//   resp_valid/rdata/error   one-cycle completion pulse with extended load data or error
//   LSU_dmem_*               word index, write data, write/read enables, read data back
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] LSU_dmem_address,
  output logic [31:0] LSU_dmem_data_in,
  output logic        LSU_dmem_mem_write,
  output logic        LSU_dmem_mem_read,
  input  logic [31:0] LSU_dmem_data_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state;
  logic        wr_q, sgn_q;
  logic [1:0]  size_q, ofs_q;
  logic [31:0] wdata_q;
  logic        req_err, needs_read;
  logic [4:0]  shift;
  logic [31:0] mask, lane, ext, merged;
  // Lanes are big-endian: byte offset 0 is the most significant byte.
  always_comb begin
    req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
              req_addr >= 32'(4 * DEPTH_WORDS);
    needs_read = !req_write || req_size != 2'b10;
    shift = size_q == 2'b00 ? {~ofs_q, 3'b000} : size_q == 2'b01 ? {~ofs_q[1], 4'b0000} : 5'd0;
    mask = size_q == 2'b00 ? 32'h0000_00ff << shift :
           size_q == 2'b01 ? 32'h0000_ffff << shift : 32'hffff_ffff;
    lane = LSU_dmem_data_out >> shift;
    ext = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
          size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : lane;
    merged = (LSU_dmem_data_out & ~mask) | ((wdata_q << shift) & mask);
  end
  assign req_ready = state == IDLE && !SYS_reset;
  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      LSU_dmem_address <= 32'd0;
      LSU_dmem_data_in <= 32'd0;
      LSU_dmem_mem_write <= 1'b0;
      LSU_dmem_mem_read <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q <= req_write;
          size_q <= req_size;
          sgn_q <= req_signed;
          ofs_q <= req_addr[1:0];
          wdata_q <= req_wdata;
          LSU_dmem_address <= {2'b00, req_addr[31:2]};
          if (req_err) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end else if (needs_read) begin
            state <= READ;
            LSU_dmem_mem_read <= 1'b1;
          end else begin
            state <= WRITE;
            LSU_dmem_mem_write <= 1'b1;
            LSU_dmem_data_in <= req_wdata;
          end
        end
        READ: begin
          LSU_dmem_mem_read <= 1'b0;
          if (wr_q) begin
            state <= WRITE;
            LSU_dmem_mem_write <= 1'b1;
            LSU_dmem_data_in <= merged;
          end else begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ext;
          end
        end
        WRITE: begin
          state <= RESP;
          LSU_dmem_mem_write <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: table, directed and random checks of dmem_lsu against a byte-level memory model
module tb_dmem_lsu;
  localparam int DW = 256;
  logic clk = 1'b0, SYS_reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic resp_valid, resp_error, LSU_dmem_mem_write, LSU_dmem_mem_read;
  logic [31:0] resp_rdata, LSU_dmem_address, LSU_dmem_data_in, LSU_dmem_data_out;
  always #5 clk = ~clk;
  dmem_lsu #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .SYS_reset(SYS_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .LSU_dmem_address(LSU_dmem_address),
    .LSU_dmem_data_in(LSU_dmem_data_in), .LSU_dmem_mem_write(LSU_dmem_mem_write),
    .LSU_dmem_mem_read(LSU_dmem_mem_read), .LSU_dmem_data_out(LSU_dmem_data_out)
  );
  logic [31:0] mem [DW];
  logic [7:0] rmem [4*DW];
  assign LSU_dmem_data_out = mem[LSU_dmem_address[7:0]];
  always @(posedge clk) if (LSU_dmem_mem_write) mem[LSU_dmem_address[7:0]] <= LSU_dmem_data_in;
  int vectors = 0, miscompares = 0;
  logic both_seen = 1'b0;
  always @(negedge clk) if (LSU_dmem_mem_read && LSU_dmem_mem_write) both_seen = 1'b1;
  typedef struct {
    logic wr; logic [1:0] sz; logic sg; logic [31:0] a, wd, rd; logic er; int lat;
  } vec_t;
  vec_t tbl[$];
  vec_t hs[3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference: memory as a flat byte array, byte 4k being the MSB of word k.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    er = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'(4*DW);
    rd = 32'd0;
    lat = er ? 1 : (wr && n < 4) ? 3 : 2;
    if (!er) begin
      if (wr) for (int i = 0; i < n; i++) rmem[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
      else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(rmem[int'(a) + i]);
        if (sg && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
        rd = v[31:0];
      end
    end
  endtask
  task automatic xact(input vec_t t, input string nm);
    int lat = 0, nr = 0, nw = 0;
    bit done = 0;
    @(negedge clk);
    req_write = t.wr; req_size = t.sz; req_signed = t.sg; req_addr = t.a; req_wdata = t.wd;
    req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      nr += int'(LSU_dmem_mem_read);
      nw += int'(LSU_dmem_mem_write);
      if (LSU_dmem_mem_read || LSU_dmem_mem_write) chk({nm, " addr"}, LSU_dmem_address, t.a >> 2);
      if (resp_valid) begin
        lat = c; done = 1;
        chk({nm, " err"}, 32'(resp_error), 32'(t.er));
        chk({nm, " rdata"}, resp_rdata, t.rd);
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(t.lat));
    chk({nm, " reads"}, 32'(nr), (!t.er && (!t.wr || t.sz != 2'd2)) ? 32'd1 : 32'd0);
    chk({nm, " writes"}, 32'(nw), (!t.er && t.wr) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({nm, " pulse"}, 32'(resp_valid), 32'd0);
  endtask
  initial begin
    vec_t t;
    logic [31:0] rd;
    logic er;
    int lat;
    logic [31:0] got_rd[$];
    logic got_er[$];
    bit bad;
    for (int k = 0; k < DW; k++) mem[k] = 32'd0;
    for (int k = 0; k < 4*DW; k++) rmem[k] = 8'd0;
    mem[3] = 32'h1122_3344; mem[4] = 32'h8001_7fff;
    {rmem[12], rmem[13], rmem[14], rmem[15]} = 32'h1122_3344;
    {rmem[16], rmem[17], rmem[18], rmem[19]} = 32'h8001_7fff;
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h008, 32'hdeadbeef, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h008, 32'h0, 32'hdeadbeef, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h00c, 32'h0, 32'h11223344, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h00d, 32'h000000aa, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h00d, 32'h0, 32'h000000aa, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h00d, 32'h0, 32'hffffffaa, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h00c, 32'h0, 32'h11aa3344, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h010, 32'h0, 32'hffff8001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h010, 32'h0, 32'h00008001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 32'h00007fff, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h012, 32'h00001234, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'h80011234, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h005, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h3ff, 32'h00000080, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h3ff, 32'h0, 32'hffffff80, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h3fc, 32'hffffff5a, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h3fc, 32'h0, 32'h5a000080, 1'b0, 2});
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset mem_rw", {30'd0, LSU_dmem_mem_read, LSU_dmem_mem_write}, 32'd0);
    SYS_reset = 1'b0;
    #1 chk("post-reset ready", 32'(req_ready), 32'd1);
    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, er, lat);
      xact(tbl[i], $sformatf("tbl%0d", i));
    end
    // Reset while a byte store is in its read cycle: the write must never happen.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
    req_valid = 1'b1;
    chk("rstop ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstop read", 32'(LSU_dmem_mem_read), 32'd1);
    SYS_reset = 1'b1;
    #1 chk("rstop ready in reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    SYS_reset = 1'b0;
    lat = 0;
    repeat (6) begin
      lat += int'(LSU_dmem_mem_write) + int'(resp_valid);
      @(negedge clk);
    end
    chk("rstop no write/resp", 32'(lat), 32'd0);
    chk("rstop idle ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 200; i++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.sz = 2'($urandom_range(0, 3));
      t.sg = 1'($urandom_range(0, 1));
      t.a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 1100)) : 32'($urandom_range(0, 1023));
      t.wd = $urandom;
      model(t.wr, t.sz, t.sg, t.a, t.wd, t.rd, t.er, t.lat);
      xact(t, $sformatf("rnd%0d", i));
    end
    hs[0] = '{1'b1, 2'd2, 1'b0, 32'h020, 32'hcafef00d, 32'h0, 1'b0, 0};
    hs[1] = '{1'b0, 2'd1, 1'b1, 32'h022, 32'h0, 32'h0, 1'b0, 0};
    hs[2] = '{1'b0, 2'd0, 1'b0, 32'h021, 32'h0, 32'h0, 1'b0, 0};
    for (int i = 0; i < 3; i++) model(hs[i].wr, hs[i].sz, hs[i].sg, hs[i].a, hs[i].wd, hs[i].rd, hs[i].er, hs[i].lat);
    @(negedge clk);
    fork
      begin
        for (int r = 0; r < 3; r++) begin
          req_write = hs[r].wr; req_size = hs[r].sz; req_signed = hs[r].sg;
          req_addr = hs[r].a; req_wdata = hs[r].wd; req_valid = 1'b1;
          for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
          @(posedge clk);
          #1;
        end
        req_valid = 1'b0;
      end
      repeat (30) begin
        @(negedge clk);
        if (resp_valid) begin got_rd.push_back(resp_rdata); got_er.push_back(resp_error); end
      end
    join
    chk("hs resp count", 32'(got_rd.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_rd.size(); i++) begin
      chk($sformatf("hs%0d rdata", i), got_rd[i], hs[i].rd);
      chk($sformatf("hs%0d err", i), 32'(got_er[i]), 32'(hs[i].er));
    end
    bad = 0;
    for (int k = 0; k < DW; k++)
      if (mem[k] !== {rmem[4*k], rmem[4*k+1], rmem[4*k+2], rmem[4*k+3]}) bad = 1;
    chk("mem image", 32'(bad), 32'd0);
    chk("rd/wr exclusive", 32'(both_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that drives the word-indexed data memory on behalf of the MIPS pipeline's MEM stage.
- Accepts byte, halfword and word load/store requests through a valid/ready handshake, and converts byte addresses to word indices.
- Sub-word stores are done as a read-modify-write: one read cycle, then one write cycle.
- Misaligned and out-of-range accesses return an error response and never touch memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in data memory; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- SYS_reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  sign-extend sub-word loads (lb/lh); 0 = zero-extend (lbu/lhu).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_error  output  1  qualified by resp_valid; misaligned, out-of-range or reserved size.
- LSU_dmem_address  output  32  word index = req_addr >> 2.
- LSU_dmem_data_in  output  32  write data to memory.
- LSU_dmem_mem_write  output  1  memory write enable.
- LSU_dmem_mem_read  output  1  memory read enable.
- LSU_dmem_data_out  input  32  combinational read data from memory.

Behaviour:
- Reset (SYS_reset=1 at a rising edge), regardless of state:
  - FSM returns to IDLE and any in-flight request is dropped with no response.
  - All memory outputs, resp_valid, resp_error and resp_rdata = 0; req_ready = 0 during the reset cycle.
  - A sub-word store aborted between its READ and WRITE cycles must not issue the write.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch write, size, signed, addr and wdata, then check the request.
    - Error (size=11; half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH_WORDS) -> RESP with error=1.
    - Load or sub-word store -> READ.
    - Word store -> WRITE.
  - READ: mem_read=1, address = word index. Capture LSU_dmem_data_out at the clock edge.
    - Load -> RESP.
    - Sub-word store -> WRITE.
  - WRITE: mem_write=1, data_in = merged word (sub-word) or wdata (word). -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
- req_ready is 1 only in IDLE. Requests presented in other states are ignored; the requester holds them until it sees req_ready.
- mem_read and mem_write are never both 1 in the same cycle. Both are 0 outside READ and WRITE.
- Memory outputs are registered or decoded from state only; they have no combinational path from the req_* inputs.
- Byte lanes are big-endian:
  - addr[1:0]=0 selects bits [31:24], and addr[1:0]=3 selects bits [7:0].
  - A halfword at addr[1]=0 is [31:16]; at addr[1]=1 it is [15:0].
- Load extraction:
  - The selected lane is shifted to the LSBs.
  - It is sign-extended if req_signed=1, else zero-extended.
  - Word loads ignore req_signed.
- Store merge: only the selected lane is replaced with req_wdata's low byte or half. All other bits come from the READ capture.
- Latency, with acceptance at edge N:
  - Error: resp_valid in cycle N+1.
  - Load or word store: resp_valid in cycle N+2.
  - Sub-word store: resp_valid in cycle N+3.
- Back-to-back: the next request can be accepted in the cycle after RESP. Throughput is one request per 3–4 cycles.

Test Plan:
- Reset mid-op: start sb to addr 0x10; assert SYS_reset during READ -> no mem_write pulse ever, no resp_valid; IDLE with req_ready=1 after reset deasserts.
- Word store/load: sw 0xDEADBEEF to 0x08 -> mem_write with address=2, data_in=0xDEADBEEF, resp at N+2; then lw 0x08 -> resp_rdata=0xDEADBEEF, error=0.
- Byte store merge: word 3 = 0x11223344; sb 0xAA to 0x0D -> READ then WRITE data_in=0x11AA3344, resp at N+3; lbu 0x0D -> 0x000000AA; lb 0x0D -> 0xFFFFFFAA.
- Halfword: word 4 = 0x8001_7FFF; lh 0x10 -> 0xFFFF8001; lhu 0x10 -> 0x00008001; lh 0x12 -> 0x00007FFF; sh 0x1234 to 0x12 -> word 4 = 0x80011234.
- Errors: lw 0x06, lh 0x05, size=11, sw 0x400 (DEPTH_WORDS=256) -> each gives resp_valid at N+1 with error=1, rdata=0, and no mem_read/mem_write asserted.
- Handshake: hold req_valid high with 3 different requests queued -> each accepted only in IDLE, executed in order, exactly one resp_valid per request.
